// File: rtl/usb_rx_pkg.sv
// Shared USB receive-path types: line states, monitor FSM states, and line decode.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LS_SE0,
    LS_J,
    LS_K,
    LS_SE1
  } line_state_t;

  typedef enum logic [1:0] {
    ACTIVE,
    SE0_RUN,
    BUS_RESET
  } mon_state_t;

  // Full-speed polarity: J = (1,0), K = (0,1).
  function automatic line_state_t decode_line(input logic d_plus, input logic d_minus);
    line_state_t ls;
    ls = LS_SE0;
    case ({d_plus, d_minus})
      2'b00:   ls = LS_SE0;
      2'b10:   ls = LS_J;
      2'b01:   ls = LS_K;
      2'b11:   ls = LS_SE1;
      default: ls = LS_SE0;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_line_monitor.sv
// USB receive line-state monitor: EOP/EOP error, SE1 error, bus reset and idle detection.
// Everything advances only on bit-sample strobes; pulses last one clk.
module usb_line_monitor
  import usb_rx_pkg::*;
#(
  parameter int unsigned EOP_SE0_MIN    = 2,
  parameter int unsigned EOP_SE0_MAX    = 3,
  parameter int unsigned BUS_RESET_BITS = 30,
  parameter int unsigned IDLE_BITS      = 7
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  input  logic shift_enable,
  output logic eop,
  output logic eop_err,
  output logic se1_err,
  output logic bus_reset,
  output logic bus_reset_active,
  output logic line_idle
);

  localparam int unsigned SE0_W = $clog2(BUS_RESET_BITS + 1);
  localparam int unsigned J_W   = $clog2(IDLE_BITS + 1);

  localparam logic [SE0_W-1:0] SE0_RESET_CNT = SE0_W'(BUS_RESET_BITS);
  localparam logic [SE0_W-1:0] SE0_EOP_MIN   = SE0_W'(EOP_SE0_MIN);
  localparam logic [SE0_W-1:0] SE0_EOP_MAX   = SE0_W'(EOP_SE0_MAX);
  localparam logic [J_W-1:0]   J_IDLE_CNT    = J_W'(IDLE_BITS);

  // Reject illegal parameter orderings at elaboration
  if (EOP_SE0_MIN < 1) begin : g_bad_eop_min
    $fatal(1, "usb_line_monitor: EOP_SE0_MIN must be >= 1");
  end
  if (EOP_SE0_MAX < EOP_SE0_MIN) begin : g_bad_eop_max
    $fatal(1, "usb_line_monitor: EOP_SE0_MAX must be >= EOP_SE0_MIN");
  end
  if (BUS_RESET_BITS <= EOP_SE0_MAX) begin : g_bad_bus_reset
    $fatal(1, "usb_line_monitor: BUS_RESET_BITS must be > EOP_SE0_MAX");
  end
  if (IDLE_BITS < 1) begin : g_bad_idle
    $fatal(1, "usb_line_monitor: IDLE_BITS must be >= 1");
  end

  mon_state_t       r_state;
  mon_state_t       w_state_next;
  logic [SE0_W-1:0] r_se0_cnt;
  logic [SE0_W-1:0] w_se0_next;
  logic [SE0_W-1:0] w_se0_inc;
  logic [J_W-1:0]   r_j_cnt;
  logic [J_W-1:0]   w_j_next;
  logic [J_W-1:0]   w_j_inc;
  logic             w_se0_legal;
  line_state_t      w_line;

  logic r_eop, r_eop_err, r_se1_err, r_bus_reset, r_bus_reset_active, r_line_idle;
  logic w_eop_next, w_eop_err_next, w_se1_err_next, w_bus_reset_next;

  assign w_line = decode_line(d_plus_sync, d_minus_sync);

  // Next-state, counter and pulse decode for the current sample
  always_comb begin
    w_state_next     = r_state;
    w_se0_next       = r_se0_cnt;
    w_j_next         = r_j_cnt;
    w_eop_next       = 1'b0;
    w_eop_err_next   = 1'b0;
    w_se1_err_next   = 1'b0;
    w_bus_reset_next = 1'b0;
    w_se0_inc        = (r_se0_cnt == SE0_RESET_CNT) ? r_se0_cnt : r_se0_cnt + SE0_W'(1);
    w_j_inc          = (r_j_cnt == J_IDLE_CNT) ? r_j_cnt : r_j_cnt + J_W'(1);
    w_se0_legal      = (r_se0_cnt >= SE0_EOP_MIN) && (r_se0_cnt <= SE0_EOP_MAX);

    case (r_state)
      ACTIVE: begin
        case (w_line)
          LS_SE0: begin
            w_state_next = SE0_RUN;
            w_se0_next   = SE0_W'(1);
            w_j_next     = '0;
          end
          LS_J:    w_j_next = w_j_inc;
          LS_K:    w_j_next = '0;
          default: begin
            w_se1_err_next = 1'b1;
            w_j_next       = '0;
          end
        endcase
      end

      SE0_RUN: begin
        case (w_line)
          LS_SE0: begin
            w_se0_next = w_se0_inc;
            if (w_se0_inc == SE0_RESET_CNT) begin
              w_state_next     = BUS_RESET;
              w_bus_reset_next = 1'b1;
            end
          end
          LS_J: begin
            w_eop_next     = w_se0_legal;
            w_eop_err_next = !w_se0_legal;
            w_state_next   = ACTIVE;
            w_j_next       = J_W'(1);
            w_se0_next     = '0;
          end
          LS_K: begin
            w_eop_err_next = 1'b1;
            w_state_next   = ACTIVE;
            w_j_next       = '0;
            w_se0_next     = '0;
          end
          default: begin
            w_eop_err_next = 1'b1;
            w_se1_err_next = 1'b1;
            w_state_next   = ACTIVE;
            w_j_next       = '0;
            w_se0_next     = '0;
          end
        endcase
      end

      BUS_RESET: begin
        case (w_line)
          LS_SE0: ;  // reset persists silently
          LS_J: begin
            w_state_next = ACTIVE;
            w_j_next     = J_W'(1);
            w_se0_next   = '0;
          end
          LS_K: begin
            w_state_next = ACTIVE;
            w_j_next     = '0;
            w_se0_next   = '0;
          end
          default: w_se1_err_next = 1'b1;
        endcase
      end

      default: begin
        w_state_next = ACTIVE;
        w_se0_next   = '0;
        w_j_next     = '0;
      end
    endcase
  end

  // State, counters and registered outputs; pulses drop on non-sample clocks
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state            <= ACTIVE;
      r_se0_cnt          <= '0;
      r_j_cnt            <= '0;
      r_eop              <= 1'b0;
      r_eop_err          <= 1'b0;
      r_se1_err          <= 1'b0;
      r_bus_reset        <= 1'b0;
      r_bus_reset_active <= 1'b0;
      r_line_idle        <= 1'b0;
    end else if (shift_enable) begin
      r_state            <= w_state_next;
      r_se0_cnt          <= w_se0_next;
      r_j_cnt            <= w_j_next;
      r_eop              <= w_eop_next;
      r_eop_err          <= w_eop_err_next;
      r_se1_err          <= w_se1_err_next;
      r_bus_reset        <= w_bus_reset_next;
      r_bus_reset_active <= (w_state_next == BUS_RESET);
      r_line_idle        <= (w_j_next == J_IDLE_CNT);
    end else begin
      r_eop       <= 1'b0;
      r_eop_err   <= 1'b0;
      r_se1_err   <= 1'b0;
      r_bus_reset <= 1'b0;
    end
  end

  assign eop              = r_eop;
  assign eop_err          = r_eop_err;
  assign se1_err          = r_se1_err;
  assign bus_reset        = r_bus_reset;
  assign bus_reset_active = r_bus_reset_active;
  assign line_idle        = r_line_idle;

endmodule

// File: tb/tb_usb_line_monitor.sv
// Self-checking bench for usb_line_monitor: directed scenarios plus randomized line traffic,
// compared every cycle against a run-length model of the line.
module tb_usb_line_monitor;

  localparam int unsigned P_MIN  = 2;
  localparam int unsigned P_MAX  = 3;
  localparam int unsigned P_BRB  = 30;
  localparam int unsigned P_IDLE = 7;

  localparam int SE0 = 0;
  localparam int J   = 1;
  localparam int K   = 2;
  localparam int SE1 = 3;

  logic clk = 1'b0;
  logic n_rst;
  logic d_plus, d_minus, shift_enable;
  logic eop, eop_err, se1_err, bus_reset, bus_reset_active, line_idle;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  usb_line_monitor #(
    .EOP_SE0_MIN   (P_MIN),
    .EOP_SE0_MAX   (P_MAX),
    .BUS_RESET_BITS(P_BRB),
    .IDLE_BITS     (P_IDLE)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .d_plus_sync     (d_plus),
    .d_minus_sync    (d_minus),
    .shift_enable    (shift_enable),
    .eop             (eop),
    .eop_err         (eop_err),
    .se1_err         (se1_err),
    .bus_reset       (bus_reset),
    .bus_reset_active(bus_reset_active),
    .line_idle       (line_idle)
  );

  // Model: length of the current SE0 run, length of the trailing J run, and whether the
  // line is in a declared bus reset. Pulses are what the last sample produced.
  int m_se0   = 0;
  int m_jrun  = 0;
  bit m_inrst = 1'b0;
  bit m_eop = 1'b0, m_eop_err = 1'b0, m_se1 = 1'b0, m_br = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_se0 <= 0; m_jrun <= 0; m_inrst <= 1'b0;
      m_eop <= 1'b0; m_eop_err <= 1'b0; m_se1 <= 1'b0; m_br <= 1'b0;
    end else begin : upd
      int se0, jr, ls;
      bit inr, e, ee, s1, br;
      se0 = m_se0; jr = m_jrun; inr = m_inrst;
      e = 1'b0; ee = 1'b0; s1 = 1'b0; br = 1'b0;
      if (shift_enable) begin
        if (d_plus && !d_minus)      ls = J;
        else if (!d_plus && d_minus) ls = K;
        else if (d_plus)             ls = SE1;
        else                         ls = SE0;
        case (ls)
          SE0: begin
            if (!inr) begin
              se0 = se0 + 1;
              if (se0 == P_BRB) begin br = 1'b1; inr = 1'b1; end
            end
            jr = 0;
          end
          J: begin
            if (inr) inr = 1'b0;
            else if (se0 > 0) begin
              if (se0 >= P_MIN && se0 <= P_MAX) e = 1'b1;
              else ee = 1'b1;
            end
            se0 = 0;
            if (jr < 1000) jr = jr + 1;
          end
          K: begin
            if (!inr && se0 > 0) ee = 1'b1;
            inr = 1'b0; se0 = 0; jr = 0;
          end
          default: begin
            s1 = 1'b1;
            if (!inr && se0 > 0) ee = 1'b1;
            if (!inr) se0 = 0;
            jr = 0;
          end
        endcase
      end
      m_se0 <= se0; m_jrun <= jr; m_inrst <= inr;
      m_eop <= e; m_eop_err <= ee; m_se1 <= s1; m_br <= br;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Pin both the DUT and the model to a hand-derived value
  task automatic pin(input string name, input logic dut_v, input logic model_v, input logic exp);
    chk(name, dut_v, exp);
    chk({"model_", name}, model_v, exp);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("eop", eop, m_eop);
    chk("eop_err", eop_err, m_eop_err);
    chk("se1_err", se1_err, m_se1);
    chk("bus_reset", bus_reset, m_br);
    chk("bus_reset_active", bus_reset_active, m_inrst);
    chk("line_idle", line_idle, m_jrun >= P_IDLE);
  end

  task automatic step(input int ls, input bit en);
    @(negedge clk);
    case (ls)
      SE0:     begin d_plus = 1'b0; d_minus = 1'b0; end
      J:       begin d_plus = 1'b1; d_minus = 1'b0; end
      K:       begin d_plus = 1'b0; d_minus = 1'b1; end
      default: begin d_plus = 1'b1; d_minus = 1'b1; end
    endcase
    shift_enable = en;
  endtask

  // One sample, then settle just after the edge that consumes it
  task automatic samp(input int ls);
    step(ls, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    shift_enable = 1'b0;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0; shift_enable = 1'b0; d_plus = 1'b1; d_minus = 1'b0;
    do_reset();
    #1;
    pin("rst_eop", eop, m_eop, 1'b0);
    pin("rst_line_idle", line_idle, (m_jrun >= P_IDLE), 1'b0);
    pin("rst_bus_reset_active", bus_reset_active, m_inrst, 1'b0);

    // J x8, SE0 x2, J: idle rises after the 7th J, legal EOP
    for (int i = 1; i <= 8; i++) begin
      samp(J);
      if (i == 6) pin("idle_after_6j", line_idle, (m_jrun >= P_IDLE), 1'b0);
      if (i == 7) pin("idle_after_7j", line_idle, (m_jrun >= P_IDLE), 1'b1);
    end
    samp(SE0);
    pin("idle_after_se0", line_idle, (m_jrun >= P_IDLE), 1'b0);
    samp(SE0);
    samp(J);
    pin("eop_legal", eop, m_eop, 1'b1);
    pin("eop_legal_no_err", eop_err, m_eop_err, 1'b0);
    samp(J);
    pin("eop_one_cycle", eop, m_eop, 1'b0);

    // Too-short and too-long SE0 runs
    samp(SE0); samp(J);
    pin("short_eop_err", eop_err, m_eop_err, 1'b1);
    pin("short_no_eop", eop, m_eop, 1'b0);
    for (int i = 0; i < 4; i++) samp(SE0);
    samp(J);
    pin("long_eop_err", eop_err, m_eop_err, 1'b1);
    pin("long_no_eop", eop, m_eop, 1'b0);

    // SE0 run ended by K, and by SE1
    samp(SE0); samp(SE0); samp(K);
    pin("k_eop_err", eop_err, m_eop_err, 1'b1);
    samp(SE0); samp(SE1);
    pin("se1_eop_err", eop_err, m_eop_err, 1'b1);
    pin("se1_se1_err", se1_err, m_se1, 1'b1);

    // Bus reset
    samp(J);
    for (int i = 1; i <= 30; i++) begin
      samp(SE0);
      if (i == 29) pin("br_not_yet", bus_reset, m_br, 1'b0);
      if (i == 30) begin
        pin("br_pulse", bus_reset, m_br, 1'b1);
        pin("br_active", bus_reset_active, m_inrst, 1'b1);
      end
    end
    for (int i = 0; i < 10; i++) begin
      samp(SE0);
      pin("br_no_repeat", bus_reset, m_br, 1'b0);
    end
    pin("br_still_active", bus_reset_active, m_inrst, 1'b1);
    samp(J);
    pin("br_cleared", bus_reset_active, m_inrst, 1'b0);
    pin("br_exit_no_eop", eop, m_eop, 1'b0);
    pin("br_exit_no_eop_err", eop_err, m_eop_err, 1'b0);

    // Strobe gap in the middle of a legal SE0 run
    samp(J); samp(SE0); samp(SE0);
    for (int i = 0; i < 5; i++) begin
      step(i % 4, 1'b0);
      @(posedge clk); #1;
      pin("gap_no_eop", eop, m_eop, 1'b0);
      pin("gap_no_eop_err", eop_err, m_eop_err, 1'b0);
    end
    samp(J);
    pin("gap_eop", eop, m_eop, 1'b1);

    // Reset during an SE0 run, then during a bus reset
    samp(J); samp(SE0); samp(SE0);
    #2; shift_enable = 1'b0; n_rst = 1'b0; #1;
    pin("midrst_eop", eop, m_eop, 1'b0);
    pin("midrst_bra", bus_reset_active, m_inrst, 1'b0);
    @(negedge clk); n_rst = 1'b1;
    samp(J);
    pin("after_rst_no_eop", eop, m_eop, 1'b0);
    pin("after_rst_no_eop_err", eop_err, m_eop_err, 1'b0);
    for (int i = 0; i < 30; i++) samp(SE0);
    #2; shift_enable = 1'b0; n_rst = 1'b0; #1;
    pin("brrst_bra", bus_reset_active, m_inrst, 1'b0);
    pin("brrst_br", bus_reset, m_br, 1'b0);
    @(negedge clk); n_rst = 1'b1;

    // Randomized runs with strobe gaps, noise in gaps and occasional resets
    for (int r = 0; r < 600; r++) begin
      int ls, len;
      ls = $urandom_range(0, 3);
      if (ls == SE0) len = ($urandom_range(0, 9) == 0) ? $urandom_range(26, 36)
                                                       : $urandom_range(1, 5);
      else if (ls == SE1) len = 1;
      else len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) step($urandom_range(0, 3), 1'b0);
        step(ls, 1'b1);
      end
      if ($urandom_range(0, 79) == 0) begin
        @(posedge clk); #3;
        shift_enable = 1'b0; n_rst = 1'b0;
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1;
      end
    end
    repeat (3) step(J, 1'b0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
